mycpu_lsu: RTL and testbench
============================

MYCPU_LSU -- requirements
Module: mycpu_lsu

Interface
REQ-001 clk  in  1  pipeline clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, asynchronous, active-low (asserted at 0).
REQ-003 in_valid  in  1  instruction from ID/EX presented.
REQ-004 in_ready  out  1  LSU accepts this cycle; transfer when in_valid && in_ready.
REQ-005 c8  in  6  mem control: [0] sign-extend, [3:1] size (000 B, 001 H, 010 W, 011 WL, 100 WR), [4] store, [5] load.
REQ-006 addr  in  32  effective address / ALU result for non-mem ops.
REQ-007 rt_data  in  32  store data; old rt value for LWL/LWR merge.
REQ-008 tgt_reg  in  5  destination register; wen_in  in  1  reg-file write enable.
REQ-009 data_req, data_wr  out  1 each  SRAM request, 1 = write.
REQ-010 data_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
REQ-011 data_wstrb  out  4  byte strobes; data_wdata  out  32  lane-shifted store data.
REQ-012 data_addr_ok, data_data_ok  in  1 each  SRAM accepts request / returns response; data_rdata  in  32.
REQ-013 out_valid  out  1, out_ready  in  1  result handshake to WB.
REQ-014 out_result  out  32, out_tgt  out  5, out_wen  out  1  WB payload, plus out_excp  out  1 (see REQ-030).

Function
REQ-015 FSM states IDLE, REQ, WAIT, HOLD; in_ready = 1 only in IDLE, or in HOLD when out_ready.
REQ-016 Non-mem op (c8[5:4]=00) accepted: next cycle state HOLD, out_result = addr; no SRAM request.
REQ-017 Load/store accepted: next cycle state REQ; data_req = 1 with stable addr/wr/wstrb/wdata until data_addr_ok.
REQ-018 REQ and data_addr_ok same cycle: next state WAIT, data_req = 0; addr_ok and data_ok in the same cycle go straight to HOLD.
REQ-019 WAIT + data_data_ok: capture formatted result, go HOLD; data_rdata ignored outside WAIT/REQ.
REQ-020 HOLD: out_valid = 1, payload stable until out_ready; out_ready with in_valid accepts next op back-to-back (no bubble); else to IDLE.
REQ-021 Store: out_wen = 0; result ignored; response still awaited before HOLD.
REQ-022 Offset k = addr[1:0], little-endian. SB: wstrb = 1<<k, wdata = {4{rt[7:0]}}; SH: wstrb = 0011<<k, wdata = {2{rt[15:0]}}; SW: 1111.
REQ-023 SWL: wstrb = (1<<(k+1))-1, wdata = rt >> 8*(3-k); SWR: wstrb = 1111<<k (4-bit), wdata = rt << 8k.
REQ-024 LB/LBU/LH/LHU: select lane k, sign-extend if c8[0] else zero-extend; LW returns rdata.
REQ-025 LWL: result = (rdata << 8*(3-k)) | (rt_data & low (3-k) bytes); LWR: result = (rdata >> 8k) | (rt_data & high k bytes).
REQ-026 out_tgt = 0 and out_wen = 0 whenever out_valid = 0, so ID sees no false bypass target.

Reset
REQ-027 rst low: state IDLE, data_req 0, out_valid 0, out_result 0, out_tgt 0, out_wen 0, out_excp 0, in_ready 1 after release.
REQ-028 rst mid-transaction aborts it; a data_data_ok arriving after release in IDLE is ignored.

Configuration
REQ-029 Macro LSU_ALIGN_EXC_EN selects alignment checking.
REQ-030 Defined: LH/LHU/SH with addr[0]=1 or LW/SW with addr[1:0]!=0 issue no SRAM request, go HOLD with out_excp = 1, out_wen = 0, out_result = addr (BadVAddr). Undefined: out_excp tied 0, misaligned H/W uses addr[1:0] forced to 0.

Structure
REQ-031 Shared package mycpu_pkg holds c8 field positions, size codes, FSM state encoding.
REQ-032 One sub-module mycpu_lsu_align: combinational store lane/strobe generation and load extract/merge; FSM and registers stay in mycpu_lsu.

Verification
REQ-033 SB addr=0x1003, rt=0x000000A5, addr_ok immediate -> data_addr 0x1000, wstrb 1000, wdata 0xA5A5A5A5, out_wen 0.
REQ-034 LB addr=0x2001, rdata=0x12348067, data_ok after 3 cycles -> out_result 0xFFFFFF80; LBU -> 0x00000080.
REQ-035 LWL addr=0x3001, rdata=0xAABBCCDD, rt=0x11223344 -> 0xCCDD3344; LWR same inputs -> 0x11AABBCC.
REQ-036 data_addr_ok held low 5 cycles -> data_req and payload stable throughout; then one request only.
REQ-037 Back-to-back ADDU result 0x55 then LW with out_ready=1 -> no bubble; out_tgt 0 while waiting.
REQ-038 rst low during WAIT -> all outputs reset values; late data_data_ok ignored; LSU_ALIGN_EXC_EN: LW addr=0x4002 -> out_excp 1, no data_req.

Source files
------------

// File: rtl/mycpu_pkg.sv
// Shared LSU definitions: c8 field positions, access sizes, FSM states.
// Used by mycpu_lsu and mycpu_lsu_align.
package mycpu_pkg;

    localparam int C8_SEXT  = 0;
    localparam int C8_SZ_LO = 1;
    localparam int C8_SZ_HI = 3;
    localparam int C8_STORE = 4;
    localparam int C8_LOAD  = 5;

    typedef enum logic [2:0] {
        SZ_B  = 3'b000,
        SZ_H  = 3'b001,
        SZ_W  = 3'b010,
        SZ_WL = 3'b011,
        SZ_WR = 3'b100
    } size_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_e;

    function automatic logic misaligned(
        input logic [2:0] sz,
        input logic [1:0] k
    );
        return (sz == SZ_H && k[0]) ||
               (sz == SZ_W && k != 2'b00);
    endfunction

endpackage

// File: rtl/mycpu_lsu_if.sv
// Data SRAM request/response bus between the LSU (master)
// and the memory side (slave).
interface mycpu_lsu_if;

    logic        data_req;
    logic        data_wr;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    modport master (
        output data_req, data_wr, data_addr,
        output data_wstrb, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_addr,
        input  data_wstrb, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata
    );

endinterface

// File: rtl/mycpu_lsu_align.sv
// Store lane/strobe generation and load extract/merge (combinational).
// Without LSU_ALIGN_EXC_EN, misaligned H/W accesses use offset 0.
module mycpu_lsu_align
    import mycpu_pkg::*;
(
    input  logic [2:0]  size,
    input  logic        sext,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rt_data,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] ldata
);

    logic [1:0]  k;
    logic [1:0]  nk;
    logic [4:0]  sh;
    logic [4:0]  nsh;
    logic [31:0] lane;

`ifdef LSU_ALIGN_EXC_EN
    assign k = addr_lo;
`else
    assign k = misaligned(size, addr_lo) ? 2'b00 : addr_lo;
`endif

    assign nk   = 2'd3 - k;
    assign sh   = {k, 3'b000};
    assign nsh  = {nk, 3'b000};
    assign lane = rdata >> sh;

    always_comb begin
        wstrb = 4'b0000;
        wdata = rt_data;
        ldata = rdata;
        case (size)
            SZ_B: begin
                wstrb = 4'b0001 << k;
                wdata = {4{rt_data[7:0]}};
                ldata = {{24{sext & lane[7]}}, lane[7:0]};
            end
            SZ_H: begin
                wstrb = 4'b0011 << k;
                wdata = {2{rt_data[15:0]}};
                ldata = {{16{sext & lane[15]}}, lane[15:0]};
            end
            SZ_W: begin
                wstrb = 4'b1111;
            end
            // Unaligned-left/right: merge the fetched bytes into old rt
            SZ_WL: begin
                wstrb = 4'b1111 >> nk;
                wdata = rt_data >> nsh;
                ldata = (rdata << nsh) |
                        (rt_data & ~(32'hFFFF_FFFF << nsh));
            end
            SZ_WR: begin
                wstrb = 4'b1111 << k;
                wdata = rt_data << sh;
                ldata = (rdata >> sh) |
                        (rt_data & ~(32'hFFFF_FFFF >> sh));
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mycpu_lsu.sv
// Load/store unit: IDLE/REQ/WAIT/HOLD FSM between ID/EX, data SRAM and WB.
// Define LSU_ALIGN_EXC_EN to trap misaligned H/W accesses (out_excp).
module mycpu_lsu
    import mycpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  c8,
    input  logic [31:0] addr,
    input  logic [31:0] rt_data,
    input  logic [4:0]  tgt_reg,
    input  logic        wen_in,
    mycpu_lsu_if.master dbus,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [4:0]  out_tgt,
    output logic        out_wen,
    output logic        out_excp
);

    state_e      state;
    logic [2:0]  op_size;
    logic        op_sext;
    logic        op_store;
    logic        op_wen;
    logic [1:0]  op_k;
    logic [31:0] op_rt;
    logic [4:0]  op_tgt;
    logic        req_q;
    logic        wr_q;
    logic [31:0] daddr_q;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] ldata;
    logic        accept;
    logic        in_mem;
    logic        in_exc;
    logic        resp;

    assign in_ready = (state == S_IDLE) ||
                      (state == S_HOLD && out_ready);
    assign accept   = in_valid && in_ready;
    assign in_mem   = c8[C8_LOAD] | c8[C8_STORE];

`ifdef LSU_ALIGN_EXC_EN
    assign in_exc = in_mem &&
                    misaligned(c8[C8_SZ_HI:C8_SZ_LO], addr[1:0]);
`else
    assign in_exc = 1'b0;
`endif

    // A response only counts once the request itself has been taken
    assign resp = dbus.data_data_ok &&
                  (state == S_WAIT ||
                   (state == S_REQ && dbus.data_addr_ok));

    mycpu_lsu_align u_align (
        .size    (op_size),
        .sext    (op_sext),
        .addr_lo (op_k),
        .rt_data (op_rt),
        .rdata   (dbus.data_rdata),
        .wstrb   (wstrb),
        .wdata   (wdata),
        .ldata   (ldata)
    );

    assign dbus.data_req   = req_q;
    assign dbus.data_wr    = wr_q;
    assign dbus.data_addr  = daddr_q;
    assign dbus.data_wstrb = wstrb;
    assign dbus.data_wdata = wdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            req_q      <= 1'b0;
            wr_q       <= 1'b0;
            daddr_q    <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_tgt    <= '0;
            out_wen    <= 1'b0;
            out_excp   <= 1'b0;
            op_size    <= '0;
            op_sext    <= 1'b0;
            op_store   <= 1'b0;
            op_wen     <= 1'b0;
            op_k       <= '0;
            op_rt      <= '0;
            op_tgt     <= '0;
        end else begin
            unique case (state)
                S_IDLE, S_HOLD: begin
                    if (accept) begin
                        op_size  <= c8[C8_SZ_HI:C8_SZ_LO];
                        op_sext  <= c8[C8_SEXT];
                        op_store <= c8[C8_STORE];
                        op_wen   <= wen_in;
                        op_k     <= addr[1:0];
                        op_rt    <= rt_data;
                        op_tgt   <= tgt_reg;
                        if (!in_mem || in_exc) begin
                            state      <= S_HOLD;
                            out_valid  <= 1'b1;
                            out_result <= addr;
                            out_tgt    <= tgt_reg;
                            out_wen    <= wen_in & ~in_exc;
                            out_excp   <= in_exc;
                        end else begin
                            state     <= S_REQ;
                            req_q     <= 1'b1;
                            wr_q      <= c8[C8_STORE];
                            daddr_q   <= {addr[31:2], 2'b00};
                            out_valid <= 1'b0;
                            out_tgt   <= '0;
                            out_wen   <= 1'b0;
                            out_excp  <= 1'b0;
                        end
                    end else if (state == S_HOLD && out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                        out_tgt   <= '0;
                        out_wen   <= 1'b0;
                        out_excp  <= 1'b0;
                    end
                end
                S_REQ, S_WAIT: begin
                    if (dbus.data_addr_ok)
                        req_q <= 1'b0;
                    if (resp) begin
                        state      <= S_HOLD;
                        out_valid  <= 1'b1;
                        out_result <= ldata;
                        out_tgt    <= op_tgt;
                        out_wen    <= op_wen & ~op_store;
                    end else if (state == S_REQ && dbus.data_addr_ok) begin
                        state <= S_WAIT;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mycpu_lsu.sv
// Self-checking bench for mycpu_lsu: directed cases plus random ops
// checked against a byte-level reference model.
module tb_mycpu_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  c8 = '0;
    logic [31:0] addr = '0;
    logic [31:0] rt_data = '0;
    logic [4:0]  tgt_reg = '0;
    logic        wen_in = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic [4:0]  out_tgt;
    logic        out_wen;
    logic        out_excp;

    int checks = 0;
    int errors = 0;

    localparam logic [5:0] OP_ALU = 6'b000000;
    localparam logic [5:0] OP_LB  = 6'b100001;
    localparam logic [5:0] OP_LBU = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100011;
    localparam logic [5:0] OP_LHU = 6'b100010;
    localparam logic [5:0] OP_LW  = 6'b100100;
    localparam logic [5:0] OP_LWL = 6'b100110;
    localparam logic [5:0] OP_LWR = 6'b101000;
    localparam logic [5:0] OP_SB  = 6'b010000;
    localparam logic [5:0] OP_SH  = 6'b010010;
    localparam logic [5:0] OP_SW  = 6'b010100;
    localparam logic [5:0] OP_SWL = 6'b010110;
    localparam logic [5:0] OP_SWR = 6'b011000;

    mycpu_lsu_if dbus ();

    mycpu_lsu dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .c8         (c8),
        .addr       (addr),
        .rt_data    (rt_data),
        .tgt_reg    (tgt_reg),
        .wen_in     (wen_in),
        .dbus       (dbus),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tgt    (out_tgt),
        .out_wen    (out_wen),
        .out_excp   (out_excp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input string what,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s.%s obs=%08h exp=%08h",
                   tag, what, obs, exp);
        end
    endtask

    function automatic logic is_exc(input logic [5:0] op,
                                    input logic [31:0] a);
`ifdef LSU_ALIGN_EXC_EN
        if (op[5:4] == 2'b00) return 1'b0;
        if (op[3:1] == 3'd1) return a[0];
        if (op[3:1] == 3'd2) return a[1:0] != 2'b00;
        return 1'b0;
`else
        return (op[5:4] != 2'b00) && 1'b0;
`endif
    endfunction

    function automatic int eff_k(input logic [5:0] op,
                                 input logic [31:0] a);
`ifndef LSU_ALIGN_EXC_EN
        if (op[3:1] == 3'd1 && a[0]) return 0;
        if (op[3:1] == 3'd2 && a[1:0] != 2'b00) return 0;
`endif
        return int'(a[1:0]);
    endfunction

    function automatic logic [3:0] m_wstrb(input logic [5:0] op,
                                           input int k);
        logic [3:0] s;
        s = '0;
        for (int i = 0; i < 4; i++) begin
            case (op[3:1])
                3'd0: s[i] = (i == k);
                3'd1: s[i] = (i == k) || (i == k + 1);
                3'd2: s[i] = 1'b1;
                3'd3: s[i] = (i <= k);
                3'd4: s[i] = (i >= k);
                default: s[i] = 1'b0;
            endcase
        end
        return s;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [5:0] op,
                                            input int k,
                                            input logic [31:0] rt);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < 4; i++) begin
            case (op[3:1])
                3'd0: w[8*i +: 8] = rt[7:0];
                3'd1: w[8*i +: 8] = rt[8*(i%2) +: 8];
                3'd2: w[8*i +: 8] = rt[8*i +: 8];
                3'd3: if (i <= k) w[8*i +: 8] = rt[8*(i+3-k) +: 8];
                3'd4: if (i >= k) w[8*i +: 8] = rt[8*(i-k) +: 8];
                default: ;
            endcase
        end
        return w;
    endfunction

    function automatic logic [31:0] m_load(input logic [5:0] op,
                                           input int k,
                                           input logic [31:0] rt,
                                           input logic [31:0] rd);
        logic [31:0] r;
        logic [31:0] t;
        r = '0;
        t = rd >> (8 * k);
        case (op[3:1])
            3'd0: begin
                r[7:0] = t[7:0];
                if (op[0] && t[7]) r[31:8] = '1;
            end
            3'd1: begin
                r[15:0] = t[15:0];
                if (op[0] && t[15]) r[31:16] = '1;
            end
            3'd2: r = rd;
            3'd3:
                for (int j = 0; j < 4; j++)
                    if (j >= 3 - k) r[8*j +: 8] = rd[8*(j-3+k) +: 8];
                    else            r[8*j +: 8] = rt[8*j +: 8];
            3'd4:
                for (int j = 0; j < 4; j++)
                    if (j <= 3 - k) r[8*j +: 8] = rd[8*(j+k) +: 8];
                    else            r[8*j +: 8] = rt[8*j +: 8];
            default: r = rd;
        endcase
        return r;
    endfunction

    // Called and returns at a negedge (+1); leaves the DUT in HOLD
    task automatic do_op(input string tag,
                         input logic [5:0] op,
                         input logic [31:0] a,
                         input logic [31:0] rt,
                         input logic [31:0] rd,
                         input logic [4:0] tg,
                         input logic we,
                         input int ad_dly,
                         input int dt_dly,
                         input int hold_dly);
        logic mem, st, exc;
        int k;
        logic [31:0] exp_res;
        logic exp_wen;
        mem = op[5] | op[4];
        st  = op[4];
        exc = is_exc(op, a);
        k   = eff_k(op, a);
        exp_res = (!mem || exc) ? a : m_load(op, k, rt, rd);
        exp_wen = (st || exc) ? 1'b0 : we;

        in_valid = 1'b1;
        c8 = op; addr = a; rt_data = rt;
        tgt_reg = tg; wen_in = we;
        #1 chk(tag, "in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        addr = $urandom();
        rt_data = $urandom();
        tgt_reg = 5'($urandom());

        if (mem && !exc) begin
            for (int i = 0; i <= ad_dly; i++) begin
                if (i == ad_dly) begin
                    dbus.data_addr_ok = 1'b1;
                    if (dt_dly == 0) begin
                        dbus.data_data_ok = 1'b1;
                        dbus.data_rdata = rd;
                    end
                end
                chk(tag, "req", 32'(dbus.data_req), 32'd1);
                chk(tag, "daddr", dbus.data_addr, {a[31:2], 2'b00});
                chk(tag, "wr", 32'(dbus.data_wr), 32'(st));
                if (st) begin
                    chk(tag, "wstrb", 32'(dbus.data_wstrb),
                        32'(m_wstrb(op, k)));
                    chk(tag, "wdata", dbus.data_wdata,
                        m_wdata(op, k, rt));
                end
                chk(tag, "req_tgt", 32'(out_tgt), 32'd0);
                chk(tag, "req_vld", 32'(out_valid), 32'd0);
                @(negedge clk);
            end
            dbus.data_addr_ok = 1'b0;
            dbus.data_data_ok = 1'b0;
            dbus.data_rdata = $urandom();
            if (dt_dly > 0) begin
                for (int i = 0; i < dt_dly; i++) begin
                    if (i == dt_dly - 1) begin
                        dbus.data_data_ok = 1'b1;
                        dbus.data_rdata = rd;
                    end
                    chk(tag, "wait_req", 32'(dbus.data_req), 32'd0);
                    chk(tag, "wait_vld", 32'(out_valid), 32'd0);
                    chk(tag, "wait_tgt", 32'(out_tgt), 32'd0);
                    chk(tag, "wait_wen", 32'(out_wen), 32'd0);
                    @(negedge clk);
                end
                dbus.data_data_ok = 1'b0;
                dbus.data_rdata = $urandom();
            end
        end

        out_ready = 1'b0;
        #1;
        for (int i = 0; i <= hold_dly; i++) begin
            chk(tag, "out_valid", 32'(out_valid), 32'd1);
            chk(tag, "out_wen", 32'(out_wen), 32'(exp_wen));
            chk(tag, "out_excp", 32'(out_excp), 32'(exc));
            chk(tag, "hold_req", 32'(dbus.data_req), 32'd0);
            chk(tag, "hold_rdy", 32'(in_ready), 32'd0);
            if (!st || exc)
                chk(tag, "out_result", out_result, exp_res);
            if (!st && !exc)
                chk(tag, "out_tgt", 32'(out_tgt), 32'(tg));
            if (i < hold_dly) begin
                @(negedge clk);
                #1;
            end
        end
        out_ready = 1'b1;
        #1;
    endtask

    initial begin
        logic [5:0] ops [13];
        logic [5:0] op;
        ops = '{OP_ALU, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWL,
                OP_LWR, OP_SB, OP_SH, OP_SW, OP_SWL, OP_SWR};
        dbus.data_addr_ok = 1'b0;
        dbus.data_data_ok = 1'b0;
        dbus.data_rdata = '0;

        repeat (2) @(negedge clk);
        chk("reset", "req", 32'(dbus.data_req), 32'd0);
        chk("reset", "valid", 32'(out_valid), 32'd0);
        chk("reset", "result", out_result, 32'd0);
        chk("reset", "tgt", 32'(out_tgt), 32'd0);
        chk("reset", "wen", 32'(out_wen), 32'd0);
        chk("reset", "excp", 32'(out_excp), 32'd0);
        rst = 1'b1;
        #1 chk("reset", "in_ready", 32'(in_ready), 32'd1);

        do_op("sb", OP_SB, 32'h1003, 32'h0000_00A5, 32'h0,
              5'd4, 1'b1, 0, 1, 0);
        do_op("lb", OP_LB, 32'h2001, 32'h0, 32'h1234_8067,
              5'd5, 1'b1, 0, 3, 1);
        chk("lb", "const", out_result, 32'hFFFF_FF80);
        do_op("lbu", OP_LBU, 32'h2001, 32'h0, 32'h1234_8067,
              5'd5, 1'b1, 1, 3, 0);
        chk("lbu", "const", out_result, 32'h0000_0080);
        do_op("lwl", OP_LWL, 32'h3001, 32'h1122_3344, 32'hAABB_CCDD,
              5'd6, 1'b1, 0, 0, 0);
        chk("lwl", "const", out_result, 32'hCCDD_3344);
        do_op("lwr", OP_LWR, 32'h3001, 32'h1122_3344, 32'hAABB_CCDD,
              5'd6, 1'b1, 2, 1, 2);
        chk("lwr", "const", out_result, 32'h11AA_BBCC);
        do_op("stall", OP_SW, 32'h5000, 32'hDEAD_BEEF, 32'h0,
              5'd0, 1'b0, 5, 2, 0);
        do_op("addu", OP_ALU, 32'h55, 32'h0, 32'h0,
              5'd7, 1'b1, 0, 0, 0);
        chk("addu", "const", out_result, 32'h55);
        do_op("b2b_lw", OP_LW, 32'h0000_0100, 32'h0, 32'hCAFE_F00D,
              5'd8, 1'b1, 1, 2, 0);

        for (int n = 0; n < 80; n++) begin
            op = ops[$urandom_range(12, 0)];
            do_op("rnd", op, $urandom(), $urandom(), $urandom(),
                  5'($urandom()), 1'($urandom()),
                  $urandom_range(3, 0), $urandom_range(3, 0),
                  $urandom_range(2, 0));
        end

        in_valid = 1'b1;
        c8 = OP_LW; addr = 32'h6000; tgt_reg = 5'd3; wen_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        dbus.data_addr_ok = 1'b1;
        @(negedge clk);
        dbus.data_addr_ok = 1'b0;
        chk("rst_wait", "req", 32'(dbus.data_req), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_mid", "req", 32'(dbus.data_req), 32'd0);
        chk("rst_mid", "valid", 32'(out_valid), 32'd0);
        chk("rst_mid", "result", out_result, 32'd0);
        chk("rst_mid", "tgt", 32'(out_tgt), 32'd0);
        chk("rst_mid", "wen", 32'(out_wen), 32'd0);
        chk("rst_mid", "excp", 32'(out_excp), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        dbus.data_data_ok = 1'b1;
        dbus.data_rdata = 32'h1357_9BDF;
        @(negedge clk);
        dbus.data_data_ok = 1'b0;
        #1;
        chk("late_ok", "valid", 32'(out_valid), 32'd0);
        chk("late_ok", "req", 32'(dbus.data_req), 32'd0);
        chk("late_ok", "tgt", 32'(out_tgt), 32'd0);
        chk("late_ok", "in_ready", 32'(in_ready), 32'd1);

`ifdef LSU_ALIGN_EXC_EN
        do_op("exc_lw", OP_LW, 32'h4002, 32'h0, 32'h0,
              5'd9, 1'b1, 0, 0, 1);
        chk("exc_lw", "excp", 32'(out_excp), 32'd1);
`else
        do_op("mis_lw", OP_LW, 32'h4002, 32'h0, 32'h2468_ACE0,
              5'd9, 1'b1, 0, 1, 0);
        chk("mis_lw", "excp", 32'(out_excp), 32'd0);
`endif

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
